// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_core datapath: width default, opcode map, saturation limits.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADC   = 5'd1,
    OP_SUB   = 5'd2,
    OP_SBC   = 5'd3,
    OP_RSB   = 5'd4,
    OP_RSC   = 5'd5,
    OP_AND   = 5'd6,
    OP_ORR   = 5'd7,
    OP_EOR   = 5'd8,
    OP_BIC   = 5'd9,
    OP_MOV   = 5'd10,
    OP_MVN   = 5'd11,
    OP_PASSA = 5'd12,
    OP_LSL   = 5'd13,
    OP_LSR   = 5'd14,
    OP_ASR   = 5'd15,
    OP_ROR   = 5'd16,
    OP_ADD4  = 5'd17,
    OP_ADDB4 = 5'd18,
    OP_QADD  = 5'd19,
    OP_QSUB  = 5'd20
  } alu_op_e;

  localparam logic [ALU_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [ALU_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the issue logic (master) and alu_core (slave).
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [4:0]       op;
  logic [WIDTH-1:0] result;
  logic             c;
  logic             n;
  logic             v;
  logic             z;

  modport master (
    output a, b, cin, op,
    input  result, c, n, v, z
  );

  modport slave (
    input  a, b, cin, op,
    output result, c, n, v, z
  );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for LSL/LSR/ASR/ROR; returns shifted value and last bit shifted out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SH_W-1:0]  amt,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic        [WIDTH:0]   lsl_ext;
  logic        [WIDTH:0]   lsr_ext;
  logic signed [WIDTH:0]   asr_ext;
  logic        [WIDTH-1:0] ror_val;
  logic        [SH_W-1:0]  ramt;

  // One guard bit beyond the operand catches the carry-out for free.
  assign lsl_ext = {1'b0, a} << amt;
  assign lsr_ext = {a, 1'b0} >> amt;
  assign asr_ext = $signed({a, 1'b0}) >>> amt;
  assign ramt    = ~amt + 1'b1;
  assign ror_val = (a >> amt) | (a << ramt);

  always_comb begin
    result = a;
    cout   = cin;
    if (amt != '0) begin
      case (op)
        OP_LSL: begin
          result = lsl_ext[WIDTH-1:0];
          cout   = lsl_ext[WIDTH];
        end
        OP_LSR: begin
          result = lsr_ext[WIDTH:1];
          cout   = lsr_ext[0];
        end
        OP_ASR: begin
          result = asr_ext[WIDTH:1];
          cout   = asr_ext[0];
        end
        OP_ROR: begin
          result = ror_val;
          cout   = ror_val[WIDTH-1];
        end
        default: begin
          result = a;
          cout   = cin;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_core.sv
// 32-bit integer ALU with registered result and C/N/V/Z flags, one cycle latency.
// Define ALU_SAT_EN to enable QADD/QSUB (ops 19/20); otherwise they behave as reserved.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic   clk,
  input logic   reset,
  alu_if.slave  bus
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  alu_op_e          op_e;

  assign a    = bus.a;
  assign b    = bus.b;
  assign cin  = bus.cin;
  assign op_e = alu_op_e'(bus.op);

`ifdef ALU_SAT_EN
  function automatic logic [WIDTH:0] sat_addsub(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y,
                                                input logic                    sub);
    logic signed [WIDTH:0] full;
    if (sub) full = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
    else     full = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
    // Guard bit disagreeing with the sign bit means the true result left the range.
    if (full[WIDTH] != full[WIDTH-1])
      return {1'b1, (full[WIDTH] ? SAT_MIN : SAT_MAX)};
    return {1'b0, full[WIDTH-1:0]};
  endfunction
`endif

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_k;
  logic [WIDTH:0]   add_sum;
  logic             add_v;
  logic [WIDTH:0]   b_plus4;

  assign b_plus4 = {1'b0, b} + (WIDTH+1)'(4);

  // Subtraction is folded into the single adder as x + ~y + carry.
  always_comb begin
    add_x = a;
    add_y = b;
    add_k = 1'b0;
    case (op_e)
      OP_ADC:   add_k = cin;
      OP_SUB:   begin add_y = ~b; add_k = 1'b1; end
      OP_SBC:   begin add_y = ~b; add_k = cin;  end
      OP_RSB:   begin add_x = b; add_y = ~a; add_k = 1'b1; end
      OP_RSC:   begin add_x = b; add_y = ~a; add_k = cin;  end
      OP_ADD4:  add_y = WIDTH'(4);
      OP_ADDB4: add_y = b_plus4[WIDTH-1:0];
      default:  ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_k};
  assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);

  logic [WIDTH-1:0] sh_res;
  logic             sh_c;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SH_W  (SH_W)
  ) u_shifter (
    .a      (a),
    .amt    (b[SH_W-1:0]),
    .cin    (cin),
    .op     (op_e),
    .result (sh_res),
    .cout   (sh_c)
  );

  logic [WIDTH-1:0] res_nx;
  logic             c_nx;
  logic             v_nx;

  always_comb begin
    res_nx = '0;
    c_nx   = 1'b0;
    v_nx   = 1'b0;
    case (op_e)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB, OP_RSC, OP_ADD4: begin
        res_nx = add_sum[WIDTH-1:0];
        c_nx   = add_sum[WIDTH];
        v_nx   = add_v;
      end
      OP_ADDB4: begin
        res_nx = add_sum[WIDTH-1:0];
        c_nx   = add_sum[WIDTH] | b_plus4[WIDTH];
        v_nx   = add_v;
      end
      OP_AND:   begin res_nx = a & b;  c_nx = cin; end
      OP_ORR:   begin res_nx = a | b;  c_nx = cin; end
      OP_EOR:   begin res_nx = a ^ b;  c_nx = cin; end
      OP_BIC:   begin res_nx = a & ~b; c_nx = cin; end
      OP_MOV:   begin res_nx = b;      c_nx = cin; end
      OP_MVN:   begin res_nx = ~b;     c_nx = cin; end
      OP_PASSA: begin res_nx = a;      c_nx = cin; end
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        res_nx = sh_res;
        c_nx   = sh_c;
      end
`ifdef ALU_SAT_EN
      OP_QADD: {v_nx, res_nx} = sat_addsub($signed(a), $signed(b), 1'b0);
      OP_QSUB: {v_nx, res_nx} = sat_addsub($signed(a), $signed(b), 1'b1);
`endif
      default: begin
        res_nx = '0;
        c_nx   = 1'b0;
        v_nx   = 1'b0;
      end
    endcase
  end

  // ---- stage p1: output register ----
  logic [WIDTH-1:0] result_p1;
  logic             c_p1;
  logic             n_p1;
  logic             v_p1;
  logic             z_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1 <= '0;
      c_p1      <= 1'b0;
      n_p1      <= 1'b0;
      v_p1      <= 1'b0;
      z_p1      <= 1'b0;
    end else begin
      result_p1 <= res_nx;
      c_p1      <= c_nx;
      n_p1      <= res_nx[WIDTH-1];
      v_p1      <= v_nx;
      z_p1      <= (res_nx == '0);
    end
  end

  assign bus.result = result_p1;
  assign bus.c      = c_p1;
  assign bus.n      = n_p1;
  assign bus.v      = v_p1;
  assign bus.z      = z_p1;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus randomized ops against an arithmetic reference model.
module tb_alu_core;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ovf(input longint x);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  // Reference: each op evaluated from its arithmetic meaning on 64-bit integers.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                  input logic [4:0] op,
                                  output logic [31:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, t;
    longint ci, nci;
    logic [31:0] bb;
    int s;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ci  = cin ? 64'sd1 : 64'sd0;
    nci = cin ? 64'sd0 : 64'sd1;
    s   = int'(b[4:0]);
    r = 32'h0; c = 1'b0; v = 1'b0;
    case (op)
      5'd0: begin t = ua + ub;       r = t[31:0]; c = (t >= 64'sd4294967296); v = ovf(sa + sb); end
      5'd1: begin t = ua + ub + ci;  r = t[31:0]; c = (t >= 64'sd4294967296); v = ovf(sa + sb + ci); end
      5'd2: begin t = ua - ub;       r = t[31:0]; c = (t >= 0); v = ovf(sa - sb); end
      5'd3: begin t = ua - ub - nci; r = t[31:0]; c = (t >= 0); v = ovf(sa - sb - nci); end
      5'd4: begin t = ub - ua;       r = t[31:0]; c = (t >= 0); v = ovf(sb - sa); end
      5'd5: begin t = ub - ua - nci; r = t[31:0]; c = (t >= 0); v = ovf(sb - sa - nci); end
      5'd6:  begin r = a & b;  c = cin; end
      5'd7:  begin r = a | b;  c = cin; end
      5'd8:  begin r = a ^ b;  c = cin; end
      5'd9:  begin r = a & ~b; c = cin; end
      5'd10: begin r = b;      c = cin; end
      5'd11: begin r = ~b;     c = cin; end
      5'd12: begin r = a;      c = cin; end
      5'd13, 5'd14, 5'd15, 5'd16: begin
        if (s == 0) begin
          r = a; c = cin;
        end else if (op == 5'd13) begin
          t = ua * (64'sd1 <<< s); r = t[31:0]; c = t[32];
        end else if (op == 5'd14) begin
          r = a >> s; c = a[s-1];
        end else if (op == 5'd15) begin
          t = sa >>> s; r = t[31:0]; c = a[s-1];
        end else begin
          r = (a >> s) | (a << (32 - s)); c = r[31];
        end
      end
      5'd17: begin t = ua + 4; r = t[31:0]; c = (t >= 64'sd4294967296); v = ovf(sa + 4); end
      5'd18: begin
        bb = b + 32'd4;
        t  = ua + ub + 4;
        r  = t[31:0];
        c  = (t >= 64'sd4294967296);
        v  = ovf(sa + longint'($signed(bb)));
      end
`ifdef ALU_SAT_EN
      5'd19, 5'd20: begin
        t = (op == 5'd19) ? (sa + sb) : (sa - sb);
        if (t > 64'sd2147483647)       begin r = 32'h7FFFFFFF; v = 1'b1; end
        else if (t < -64'sd2147483648) begin r = 32'h80000000; v = 1'b1; end
        else                           r = t[31:0];
        c = 1'b0;
      end
`endif
      default: begin r = 32'h0; c = 1'b0; v = 1'b0; end
    endcase
  endfunction

  task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                     input logic [4:0] top, input string tag);
    logic [31:0] er;
    logic        ec, ev;
    bus.a = ta; bus.b = tb; bus.cin = tcin; bus.op = top;
    @(posedge clk);
    #1;
    ref_alu(ta, tb, tcin, top, er, ec, ev);
    chk({tag, ".res"}, bus.result, er);
    chk({tag, ".c"}, 32'(bus.c), 32'(ec));
    chk({tag, ".v"}, 32'(bus.v), 32'(ev));
    chk({tag, ".n"}, 32'(bus.n), 32'(er[31]));
    chk({tag, ".z"}, 32'(bus.z), 32'(er == 32'h0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".res"}, bus.result, 32'h0);
    chk({tag, ".c"}, 32'(bus.c), 32'h0);
    chk({tag, ".n"}, 32'(bus.n), 32'h0);
    chk({tag, ".v"}, 32'(bus.v), 32'h0);
    chk({tag, ".z"}, 32'(bus.z), 32'h0);
  endtask

  logic [31:0] edges [6];

  initial begin
    total = 0;
    bad   = 0;
    edges = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFC};

    reset = 1'b1;
    bus.a = 32'h5; bus.b = 32'h6; bus.cin = 1'b1; bus.op = OP_ADD;
    @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    run(32'h0, 32'h0, 1'b1, OP_ADD, "add0");
    chk("add0.zflag", 32'(bus.z), 32'h1);

    run(32'h53, 32'h65, 1'b1, OP_AND, "and");
    chk("and.lit", bus.result, 32'h41);
    run(32'h53, 32'h65, 1'b0, OP_ORR, "orr");
    chk("orr.lit", bus.result, 32'h77);
    run(32'h53, 32'h65, 1'b1, OP_EOR, "eor");
    chk("eor.lit", bus.result, 32'h36);
    run(32'h53, 32'h65, 1'b0, OP_BIC, "bic");
    chk("bic.lit", bus.result, 32'h12);
    run(32'h53, 32'h65, 1'b1, OP_MVN, "mvn");
    chk("mvn.lit", bus.result, 32'hFFFFFF9A);
    chk("mvn.nlit", 32'(bus.n), 32'h1);
    chk("mvn.clit", 32'(bus.c), 32'h1);

    run(32'h7FFFFFFD, 32'h2, 1'b0, OP_ADD, "addnv");
    chk("addnv.lit", bus.result, 32'h7FFFFFFF);
    run(32'h7FFFFFFF, 32'h2, 1'b0, OP_ADD, "addov");
    chk("addov.lit", bus.result, 32'h80000001);
    chk("addov.vlit", 32'(bus.v), 32'h1);

    run(32'h80000002, 32'h2, 1'b0, OP_SUB, "subnv");
    chk("subnv.lit", bus.result, 32'h80000000);
    chk("subnv.clit", 32'(bus.c), 32'h1);
    run(32'h80000000, 32'h2, 1'b0, OP_SUB, "subov");
    chk("subov.lit", bus.result, 32'h7FFFFFFE);
    chk("subov.vlit", 32'(bus.v), 32'h1);
    run(32'h1, 32'h2, 1'b1, OP_SUB, "subbr");
    chk("subbr.lit", bus.result, 32'hFFFFFFFF);
    chk("subbr.clit", 32'(bus.c), 32'h0);

    run(32'h80000001, 32'h1, 1'b0, OP_LSL, "lsl");
    chk("lsl.lit", bus.result, 32'h2);
    run(32'h80000001, 32'h1, 1'b0, OP_ASR, "asr");
    chk("asr.lit", bus.result, 32'hC0000000);
    run(32'h80000001, 32'h1, 1'b0, OP_ROR, "ror");
    chk("ror.lit", bus.result, 32'hC0000000);
    run(32'h80000001, 32'h1, 1'b0, OP_LSR, "lsr");
    run(32'h80000001, 32'h20, 1'b1, OP_LSR, "shz");
    chk("shz.lit", bus.result, 32'h80000001);
    chk("shz.clit", 32'(bus.c), 32'h1);

    run(32'h1234, 32'h5678, 1'b1, 5'd25, "rsvd");
    chk("rsvd.zlit", 32'(bus.z), 32'h1);
    run(32'h7FFFFFFF, 32'h1, 1'b1, 5'd19, "op19");
    run(32'h80000000, 32'h1, 1'b1, 5'd20, "op20");
`ifdef ALU_SAT_EN
    run(32'h7FFFFFFF, 32'h1, 1'b0, 5'd19, "qadd");
    chk("qadd.lit", bus.result, 32'h7FFFFFFF);
    chk("qadd.vlit", 32'(bus.v), 32'h1);
`endif

    bus.a = 32'h7FFFFFFF; bus.b = 32'h2; bus.cin = 1'b1; bus.op = OP_ADD;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      run(ra, rb, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the basic RISC datapath.
- Takes two operands, a carry-in and a 5-bit opcode, and computes a 32-bit result plus four condition codes: C, N, V, Z.
- Outputs are registered, giving one clock of latency, and feed the register-file write-back and the status register.

Parameters:
- WIDTH, 32, operand/result width (only 32 is required to work).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A (two's complement).
- b  in  WIDTH  operand B (two's complement).
- cin  in  1  carry-in from the status register.
- op  in  5  operation select.
- result  out  WIDTH  registered result.
- c  out  1  carry flag (registered).
- n  out  1  negative flag, equal to result[WIDTH-1].
- v  out  1  signed overflow flag.
- z  out  1  zero flag, set when result == 0.

Behaviour:
- On a rising clk edge with reset=1: result=0, c=0, n=0, v=0, z=0.
- Otherwise, on each rising edge: result and flags take the combinational function of the current a, b, cin and op. Latency is 1 cycle, with a new op every cycle.
- Reset has priority. A reset asserted mid-stream discards the in-flight value.
- Opcodes:
  - 0 ADD: a+b. c = carry out.
  - 1 ADC: a+b+cin.
  - 2 SUB: a-b. c = NOT borrow (ARM convention).
  - 3 SBC: a-b-!cin.
  - 4 RSB: b-a.
  - 5 RSC: b-a-!cin.
  - 6 AND: a&b.
  - 7 ORR: a|b.
  - 8 EOR: a^b.
  - 9 BIC: a&~b.
  - 10 MOV: b.
  - 11 MVN: ~b.
  - 12 PASSA: a.
  - 13 LSL, 14 LSR, 15 ASR, 16 ROR: shift or rotate a by b[4:0].
  - 17 ADD4: a+4.
  - 18 ADDB4: a+b+4.
  - 19-31: reserved.
- V for the add/sub family (0-5, 17, 18): set when the operands, as actually presented to the adder, have the same sign and the sum's sign differs. All sums are taken modulo 2^32.
- Logical and move ops (6-12): c = cin, v = 0.
- Shifts: c = last bit shifted out. An amount of 0 gives result = a, c = cin. v = 0.
- Reserved ops: result = 0, c = 0, v = 0, n = 0, z = 1.
- n and z are always derived from the final result.

Optional Feature:
- Macro: ALU_SAT_EN.
- When defined:
  - op 19 QADD: signed saturating a+b, clamped to 0x7FFFFFFF or 0x80000000.
  - op 20 QSUB: signed saturating a-b, clamped the same way.
  - For both, v = 1 when clamping occurred, and c = 0.
- When undefined: ops 19 and 20 behave as reserved.

Decomposition:
- Package alu_pkg holds:
  - WIDTH default;
  - the 5-bit opcode enum alu_op_e, with encodings as listed;
  - constants for the saturation limits.
- One sub-module, alu_shifter: combinational barrel shifter supporting LSL/LSR/ASR/ROR, which returns the shifted value and the carry-out.
- The adder, logic unit and output register stay in alu_core.

Test Plan:
- Reset: drive reset=1 for one edge, then check result=0 and c=n=v=z=0. Next, a=0, b=0, cin=1, op=0; one cycle later result=0, z=1, c=0, v=0.
- Logic: a=0x53, b=0x65. Required results:
  - AND → 0x41;
  - ORR → 0x77;
  - EOR → 0x36;
  - BIC → 0x12;
  - MVN → 0xFFFFFF9A with n=1.
  - c equals cin for all of these.
- ADD overflow:
  - a=0x7FFFFFFD, b=2 → 0x7FFFFFFF, v=0, n=0.
  - a=0x7FFFFFFF, b=2 → 0x80000001, v=1, n=1, c=0.
- SUB overflow:
  - a=0x80000002, b=2 → 0x80000000, n=1, v=0, c=1.
  - a=0x80000000, b=2 → 0x7FFFFFFE, v=1, n=0, c=1.
  - a=1, b=2 → 0xFFFFFFFF, c=0.
- Shifts:
  - a=0x80000001, b=1, LSL → 0x00000002, c=1.
  - ASR by 1 → 0xC0000000, c=1.
  - ROR by 1 → 0xC0000000, c=1.
  - b=0 → result=a, c=cin.
- Reserved/saturation:
  - op=25 → result 0, z=1.
  - With ALU_SAT_EN defined: QADD a=0x7FFFFFFF, b=1 → 0x7FFFFFFF, v=1.
  - Reset asserted while a valid op is presented → outputs are 0 on the next edge.
